// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module  : fetch_unit_pkg
// Brief   : Shared types for the IF stage: ibus request/response, the
//           fetch->decode payload and the fetch state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

    localparam logic [63:0] PC_INIT_DEFAULT = 64'h8000_0000;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    // 97-bit fetch->decode payload; valid sits in bit 0
    typedef struct packed {
        logic [31:0] raw_instr;
        logic [63:0] pc;
        logic        valid;
    } fetch_data_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    function automatic logic [63:0] next_pc(input logic [63:0] pc);
        return pc + 64'd4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module  : fetch_unit
// Brief   : IF stage - owns the PC, issues one ibus read at a time and hands
//           {raw_instr, pc, valid} to decode with a one-entry skid buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [63:0] PC_INIT = PC_INIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output fetch_data_t dataF
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [63:0]  pc;
    logic [63:0]  drain_addr;
    fetch_data_t  out_q;
    logic [31:0]  skid_instr;
    logic [63:0]  skid_pc;
    logic         skid_valid;
    ibus_req_t    req;
    ibus_resp_t   resp;
    logic         consume;

    assign resp       = '{data_ok: iresp_data_ok, data: iresp_data};
    assign consume    = out_q.valid && !stall;
    assign req.valid  = ((state == FETCH) || (state == DRAIN)) && !reset;
    // DRAIN keeps presenting the pre-redirect address until the bus answers
    assign req.addr   = (state == DRAIN) ? drain_addr : pc;
    assign ireq_valid = req.valid;
    assign ireq_addr  = req.addr;
    assign dataF      = out_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = ((state != HOLD) && !resp.data_ok) ? DRAIN : FETCH;
        end else begin
            case (state)
                FETCH:   if (resp.data_ok && out_q.valid && stall) state_next = HOLD;
                HOLD:    if (!stall) state_next = FETCH;
                DRAIN:   if (resp.data_ok) state_next = FETCH;
                default: state_next = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= PC_INIT;
            drain_addr <= '0;
            out_q      <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
            skid_valid <= 1'b0;
        end else if (redirect_valid) begin
            pc          <= redirect_pc;
            out_q.valid <= 1'b0;
            skid_valid  <= 1'b0;
            if (state == FETCH) begin
                drain_addr <= pc;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (resp.data_ok) begin
                        pc <= next_pc(pc);
                        if (!out_q.valid || !stall) begin
                            out_q <= '{raw_instr: resp.data, pc: pc, valid: 1'b1};
                        end else begin
                            skid_instr <= resp.data;
                            skid_pc    <= pc;
                            skid_valid <= 1'b1;
                        end
                    end else if (consume) begin
                        out_q.valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall && skid_valid) begin
                        out_q      <= '{raw_instr: skid_instr, pc: skid_pc, valid: 1'b1};
                        skid_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (consume) begin
                        out_q.valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module  : tb_fetch_unit
// Brief   : Directed and randomized self-checking bench for fetch_unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok = 1'b0;
    logic [31:0] iresp_data = '0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    fetch_data_t dataF;

    int passed = 0;
    int total  = 0;

    logic        busy;
    logic [63:0] busy_addr;
    int          wait_cnt;
    logic [63:0] exp_pc;
    int          delivered;
    logic        prev_redir;
    logic [31:0] w1 [4];

    fetch_unit #(.PC_INIT(64'h8000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dataF          (dataF)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    // Instruction memory contents as a pure function of the address
    function automatic logic [31:0] mem(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5BD1_E995;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic [63:0] p, input logic [31:0] w);
        chk({tag, ".valid"}, 64'(dataF.valid), 64'd1);
        chk({tag, ".pc"}, dataF.pc, p);
        chk({tag, ".instr"}, 64'(dataF.raw_instr), 64'(w));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        iresp_data_ok  = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        w1[0] = 32'h0000_0013;
        w1[1] = 32'h0010_0093;
        w1[2] = 32'h0020_0113;
        w1[3] = 32'h0030_0193;

        // Reset state and streaming at one instruction per cycle
        do_reset();
        chk("rst.ireq_valid", 64'(ireq_valid), 64'd0);
        chk("rst.valid", 64'(dataF.valid), 64'd0);
        chk("rst.pc", dataF.pc, 64'd0);
        chk("rst.instr", 64'(dataF.raw_instr), 64'd0);
        reset = 1'b0;
        #1;
        chk("t1.req_valid", 64'(ireq_valid), 64'd1);
        for (int k = 0; k < 4; k++) begin
            chk("t1.addr", ireq_addr, 64'h8000_0000 + 64'(4 * k));
            if (k > 0) chk_out("t1.out", 64'h8000_0000 + 64'(4 * (k - 1)), w1[k - 1]);
            iresp_data_ok = 1'b1;
            iresp_data    = w1[k];
            tick();
        end
        iresp_data_ok = 1'b0;
        chk_out("t1.last", 64'h8000_000c, w1[3]);

        // Back-pressure into the skid entry
        do_reset();
        reset = 1'b0;
        #1;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'hAAAA_0001;
        tick();
        chk_out("t2.first", 64'h8000_0000, 32'hAAAA_0001);
        chk("t2.addr1", ireq_addr, 64'h8000_0004);
        stall         = 1'b1;
        iresp_data    = 32'hBBBB_0002;
        tick();
        iresp_data_ok = 1'b0;
        chk("t2.hold_req", 64'(ireq_valid), 64'd0);
        chk_out("t2.hold_out", 64'h8000_0000, 32'hAAAA_0001);
        tick();
        chk("t2.hold_req2", 64'(ireq_valid), 64'd0);
        chk_out("t2.hold_out2", 64'h8000_0000, 32'hAAAA_0001);
        stall = 1'b0;
        tick();
        chk_out("t2.skid_out", 64'h8000_0004, 32'hBBBB_0002);
        chk("t2.resume_req", 64'(ireq_valid), 64'd1);
        chk("t2.resume_addr", ireq_addr, 64'h8000_0008);

        // Redirect while a request is in flight
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        chk("t3.drain_req", 64'(ireq_valid), 64'd1);
        chk("t3.drain_addr", ireq_addr, 64'h8000_0008);
        chk("t3.flush", 64'(dataF.valid), 64'd0);
        tick();
        chk("t3.drain_addr2", ireq_addr, 64'h8000_0008);
        iresp_data_ok = 1'b1;
        iresp_data    = 32'hDEAD_BEEF;
        tick();
        iresp_data_ok = 1'b0;
        chk("t3.new_addr", ireq_addr, 64'h8000_0100);
        chk("t3.dropped", 64'(dataF.valid), 64'd0);
        iresp_data_ok = 1'b1;
        iresp_data    = 32'hCCCC_0003;
        tick();
        iresp_data_ok = 1'b0;
        chk_out("t3.target", 64'h8000_0100, 32'hCCCC_0003);

        // Redirect coinciding with data_ok
        iresp_data_ok  = 1'b1;
        iresp_data     = 32'h1111_2222;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0400;
        tick();
        iresp_data_ok  = 1'b0;
        redirect_valid = 1'b0;
        chk("t4.addr", ireq_addr, 64'h8000_0400);
        chk("t4.req", 64'(ireq_valid), 64'd1);
        chk("t4.flush", 64'(dataF.valid), 64'd0);

        // Two redirects during DRAIN: the later one wins
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        tick();
        chk("t5.drain_addr", ireq_addr, 64'h8000_0400);
        redirect_pc = 64'h8000_0300;
        tick();
        redirect_valid = 1'b0;
        chk("t5.drain_addr2", ireq_addr, 64'h8000_0400);
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h3333_4444;
        tick();
        chk("t5.addr", ireq_addr, 64'h8000_0300);
        chk("t5.dropped", 64'(dataF.valid), 64'd0);
        iresp_data = 32'hDDDD_0004;
        tick();
        iresp_data_ok = 1'b0;
        chk_out("t5.target", 64'h8000_0300, 32'hDDDD_0004);

        // Reset during DRAIN
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0500;
        tick();
        redirect_valid = 1'b0;
        reset          = 1'b1;
        tick();
        chk("t6d.req", 64'(ireq_valid), 64'd0);
        chk("t6d.valid", 64'(dataF.valid), 64'd0);
        reset = 1'b0;
        #1;
        chk("t6d.addr", ireq_addr, 64'h8000_0000);

        // Reset during HOLD
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h5555_0005;
        tick();
        stall      = 1'b1;
        iresp_data = 32'h6666_0006;
        tick();
        iresp_data_ok = 1'b0;
        chk("t6h.hold_req", 64'(ireq_valid), 64'd0);
        reset = 1'b1;
        stall = 1'b0;
        tick();
        chk("t6h.req", 64'(ireq_valid), 64'd0);
        chk("t6h.valid", 64'(dataF.valid), 64'd0);
        reset = 1'b0;
        #1;
        chk("t6h.addr", ireq_addr, 64'h8000_0000);

        // PC wraps modulo 2^64
        iresp_data_ok  = 1'b1;
        iresp_data     = 32'h0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        iresp_data     = 32'h7777_0007;
        tick();
        iresp_data_ok = 1'b0;
        chk_out("t7.top", 64'hFFFF_FFFF_FFFF_FFFC, 32'h7777_0007);
        chk("t7.wrap", ireq_addr, 64'h0);

        // Randomized traffic against a program-order scoreboard
        do_reset();
        reset      = 1'b0;
        #1;
        busy       = 1'b0;
        busy_addr  = '0;
        wait_cnt   = 0;
        exp_pc     = 64'h8000_0000;
        delivered  = 0;
        prev_redir = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (busy) begin
                chk("rnd.bus_valid", 64'(ireq_valid), 64'd1);
                chk("rnd.bus_addr", ireq_addr, busy_addr);
            end
            if (prev_redir) chk("rnd.flush", 64'(dataF.valid), 64'd0);
            if (!busy && ireq_valid) begin
                busy      = 1'b1;
                busy_addr = ireq_addr;
                wait_cnt  = int'($urandom_range(0, 2));
            end
            iresp_data_ok = busy && (wait_cnt == 0);
            iresp_data    = iresp_data_ok ? mem(busy_addr) : $urandom;
            if (busy && wait_cnt != 0) wait_cnt--;
            stall          = ($urandom_range(0, 99) < 35);
            redirect_valid = ($urandom_range(0, 99) < 5);
            redirect_pc    = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 64'd4;
            if (dataF.valid && !stall) begin
                chk("rnd.pc", dataF.pc, exp_pc);
                chk("rnd.instr", 64'(dataF.raw_instr), 64'(mem(exp_pc)));
                exp_pc = exp_pc + 64'd4;
                delivered++;
            end
            if (redirect_valid) exp_pc = redirect_pc;
            if (iresp_data_ok) busy = 1'b0;
            prev_redir = redirect_valid;
            tick();
        end
        redirect_valid = 1'b0;
        iresp_data_ok  = 1'b0;
        stall          = 1'b0;
        chk("rnd.progress", 64'(delivered > 300), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
